// File: rtl/leitor_caminho_pkg.sv
// Shared definitions for the path reader: parameter defaults, width derivation
// and the 3-bit state encoding used by the controller FSM.
package leitor_caminho_pkg;

  localparam int DEF_NODE_WIDTH = 8;
  localparam int DEF_MAX_PATH   = 64;
  localparam int DEF_TIMEOUT    = 65535;
  localparam int TIMER_W        = 16;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_INICIAR  = 3'd1;
  localparam logic [2:0] ST_ESPERAR  = 3'd2;
  localparam logic [2:0] ST_LER      = 3'd3;
  localparam logic [2:0] ST_CAPTURAR = 3'd4;
  localparam logic [2:0] ST_ENVIAR   = 3'd5;
  localparam logic [2:0] ST_LIDO     = 3'd6;

  function automatic int calc_len_w(input int max_path);
    return $clog2(max_path + 32'sd1);
  endfunction

  // A one-entry buffer still needs a 1-bit address.
  function automatic int calc_idx_w(input int max_path);
    return (max_path > 32'sd1) ? $clog2(max_path) : 32'sd1;
  endfunction

  localparam int DEF_LEN_W = calc_len_w(DEF_MAX_PATH);
  localparam int DEF_IDX_W = calc_idx_w(DEF_MAX_PATH);

endpackage

// File: rtl/leitor_caminho_if.sv
// Host, controller and path-buffer signals of the path reader; master is the
// reader itself, slave is the surrounding system.
interface leitor_caminho_if
  import leitor_caminho_pkg::*;
#(
  parameter int NODE_WIDTH = DEF_NODE_WIDTH,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int IDX_W      = DEF_IDX_W
);
  logic                  solicitar_in;
  logic                  aguardando_in;
  logic                  caminho_pronto_in;
  logic [LEN_W-1:0]      tamanho_caminho_in;
  logic                  iniciar_out;
  logic                  lido_out;
  logic                  mem_rd_en_out;
  logic [IDX_W-1:0]      mem_addr_out;
  logic [NODE_WIDTH-1:0] mem_data_in;
  logic                  no_valid_out;
  logic [NODE_WIDTH-1:0] no_data_out;
  logic                  no_ultimo_out;
  logic                  no_ready_in;
  logic                  ocupado_out;
  logic                  sem_caminho_out;
  logic                  erro_out;

  modport master (
    input  solicitar_in, aguardando_in, caminho_pronto_in, tamanho_caminho_in,
           mem_data_in, no_ready_in,
    output iniciar_out, lido_out, mem_rd_en_out, mem_addr_out, no_valid_out,
           no_data_out, no_ultimo_out, ocupado_out, sem_caminho_out, erro_out
  );

  modport slave (
    output solicitar_in, aguardando_in, caminho_pronto_in, tamanho_caminho_in,
           mem_data_in, no_ready_in,
    input  iniciar_out, lido_out, mem_rd_en_out, mem_addr_out, no_valid_out,
           no_data_out, no_ultimo_out, ocupado_out, sem_caminho_out, erro_out
  );
endinterface

// File: rtl/leitor_caminho_contador_timeout.sv
// Wait-for-path watchdog: counts enabled cycles and flags the last allowed one.
// TIMEOUT = 0 disables it entirely.
module contador_timeout
  import leitor_caminho_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);
  logic [TIMER_W-1:0] count_r;

  // Saturating cycle counter, restarted for every new search.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {TIMER_W{1'b0}};
    end else if (clear) begin
      count_r <= {TIMER_W{1'b0}};
    end else if (enable && !terminal) begin
      count_r <= count_r + {{(TIMER_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  if (TIMEOUT == 0) begin : g_disabled
    assign terminal = 1'b0;
  end else begin : g_enabled
    assign terminal = (count_r == TIMER_W'(TIMEOUT - 1));
  end

endmodule

// File: rtl/leitor_caminho.sv
// Host-side path reader: starts the search controller, waits for a finished
// path, streams it node by node to the host, then acknowledges the read.
module leitor_caminho
  import leitor_caminho_pkg::*;
#(
  parameter int NODE_WIDTH = DEF_NODE_WIDTH,
  parameter int MAX_PATH   = DEF_MAX_PATH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input logic              clk,
  input logic              rst,
  leitor_caminho_if.master bus
);
  localparam int LEN_W = calc_len_w(MAX_PATH);
  localparam int IDX_W = calc_idx_w(MAX_PATH);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_PATH);
  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

  logic [2:0]            state_r, state_next;
  logic [LEN_W-1:0]      len_r, len_clamped;
  logic [IDX_W-1:0]      idx_r, idx_next, mem_addr_r;
  logic [NODE_WIDTH-1:0] no_data_r;
  logic no_ultimo_r, erro_r, iniciar_r, lido_r, mem_rd_en_r;
  logic no_valid_r, ocupado_r, sem_caminho_r;
  logic timeout_hit, path_empty, handshake, timer_clear, timer_enable;

  assign len_clamped  = (bus.tamanho_caminho_in > LEN_MAX) ? LEN_MAX : bus.tamanho_caminho_in;
  assign path_empty   = (len_clamped == {LEN_W{1'b0}});
  assign handshake    = (state_r == ST_ENVIAR) && no_valid_r && bus.no_ready_in;
  assign timer_clear  = (state_r == ST_INICIAR);
  assign timer_enable = (state_r == ST_ESPERAR);

  contador_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear    (timer_clear),
    .enable   (timer_enable),
    .terminal (timeout_hit)
  );

  // Next-state and node-index selection.
  always_comb begin
    state_next = state_r;
    idx_next   = idx_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.solicitar_in && bus.aguardando_in) state_next = ST_INICIAR;
        else                                        state_next = ST_IDLE;
      end
      ST_INICIAR:  state_next = ST_ESPERAR;
      ST_ESPERAR: begin
        // A path arriving on the terminal cycle beats the timeout.
        if (bus.caminho_pronto_in) begin
          idx_next = {IDX_W{1'b0}};
          if (path_empty) state_next = ST_LIDO;
          else            state_next = ST_LER;
        end else if (timeout_hit) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_ESPERAR;
        end
      end
      ST_LER:      state_next = ST_CAPTURAR;
      ST_CAPTURAR: state_next = ST_ENVIAR;
      ST_ENVIAR: begin
        if (handshake) begin
          if (no_ultimo_r) begin
            state_next = ST_LIDO;
          end else begin
            idx_next   = idx_r + IDX_ONE;
            state_next = ST_LER;
          end
        end else begin
          state_next = ST_ENVIAR;
        end
      end
      ST_LIDO:     state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_next;
  end

  // Datapath and outputs, registered from the upcoming state so every output
  // is glitch-free and independent of no_ready_in within the cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_r         <= {LEN_W{1'b0}};
      idx_r         <= {IDX_W{1'b0}};
      no_data_r     <= {NODE_WIDTH{1'b0}};
      no_ultimo_r   <= 1'b0;
      erro_r        <= 1'b0;
      iniciar_r     <= 1'b0;
      lido_r        <= 1'b0;
      mem_rd_en_r   <= 1'b0;
      mem_addr_r    <= {IDX_W{1'b0}};
      no_valid_r    <= 1'b0;
      ocupado_r     <= 1'b0;
      sem_caminho_r <= 1'b0;
    end else begin
      idx_r <= idx_next;
      if (state_r == ST_ESPERAR && bus.caminho_pronto_in) len_r <= len_clamped;
      if (state_r == ST_CAPTURAR) begin
        no_data_r   <= bus.mem_data_in;
        no_ultimo_r <= (LEN_W'(idx_r) == (len_r - LEN_ONE));
      end
      if (state_r == ST_IDLE && state_next == ST_INICIAR) begin
        erro_r <= 1'b0;
      end else if (state_r == ST_ESPERAR && !bus.caminho_pronto_in && timeout_hit) begin
        erro_r <= 1'b1;
      end
      iniciar_r     <= (state_next == ST_INICIAR);
      lido_r        <= (state_next == ST_LIDO);
      mem_rd_en_r   <= (state_next == ST_LER);
      mem_addr_r    <= (state_next == ST_LER) ? idx_next : {IDX_W{1'b0}};
      no_valid_r    <= (state_next == ST_ENVIAR);
      ocupado_r     <= (state_next != ST_IDLE);
      sem_caminho_r <= (state_r == ST_ESPERAR) && bus.caminho_pronto_in && path_empty;
    end
  end

  assign bus.iniciar_out     = iniciar_r;
  assign bus.lido_out        = lido_r;
  assign bus.mem_rd_en_out   = mem_rd_en_r;
  assign bus.mem_addr_out    = mem_addr_r;
  assign bus.no_valid_out    = no_valid_r;
  assign bus.no_data_out     = no_data_r;
  assign bus.no_ultimo_out   = no_ultimo_r;
  assign bus.ocupado_out     = ocupado_r;
  assign bus.sem_caminho_out = sem_caminho_r;
  assign bus.erro_out        = erro_r;

endmodule

// File: tb/tb_leitor_caminho.sv
// Self-checking bench for leitor_caminho: directed cases plus randomized
// transactions checked against a transaction-level reference model.
module tb_leitor_caminho;
  import leitor_caminho_pkg::*;

  localparam int NW = 8;
  localparam int MP = 64;
  localparam int TO = 10;
  localparam int LW = $clog2(MP + 1);
  localparam int IW = $clog2(MP);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  leitor_caminho_if #(.NODE_WIDTH(NW), .LEN_W(LW), .IDX_W(IW)) bus ();

  leitor_caminho #(.NODE_WIDTH(NW), .MAX_PATH(MP), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Path buffer: synchronous RAM, one-cycle read latency, with a read counter.
  logic [NW-1:0] mem [MP];
  int reads = 0;
  always @(posedge clk) begin
    if (bus.mem_rd_en_out) begin
      bus.mem_data_in <= mem[bus.mem_addr_out];
      reads <= reads + 1;
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  bit erro_exp = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_iniciar"}, bus.iniciar_out, 0);
    check_eq({tag, "_lido"},    bus.lido_out, 0);
    check_eq({tag, "_rd_en"},   bus.mem_rd_en_out, 0);
    check_eq({tag, "_addr"},    bus.mem_addr_out, 0);
    check_eq({tag, "_valid"},   bus.no_valid_out, 0);
    check_eq({tag, "_data"},    bus.no_data_out, 0);
    check_eq({tag, "_ultimo"},  bus.no_ultimo_out, 0);
    check_eq({tag, "_ocupado"}, bus.ocupado_out, 0);
    check_eq({tag, "_sem"},     bus.sem_caminho_out, 0);
    check_eq({tag, "_erro"},    bus.erro_out, 0);
  endtask

  task automatic fill_mem();
    for (int i = 0; i < MP; i++) mem[i] = NW'($urandom);
  endtask

  // One request: path ready d cycles into the wait, reported length tam.
  // rmode 0: host always ready, 1: random stalls, 2: 5-cycle stall on beat 1.
  task automatic run_txn(input int d, input int tam, input int rmode);
    int len, rd0, stall;
    len = (tam > MP) ? MP : tam;
    check_eq("idle_busy", bus.ocupado_out, 0);
    check_eq("idle_erro", bus.erro_out, erro_exp);
    bus.solicitar_in  = 1'b1;
    bus.aguardando_in = 1'b1;
    @(negedge clk);
    check_eq("start_pulse", bus.iniciar_out, 1);
    check_eq("start_busy", bus.ocupado_out, 1);
    check_eq("erro_clear", bus.erro_out, 0);
    erro_exp = 1'b0;
    bus.solicitar_in = 1'b0;
    rd0 = reads;
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      if (k == 1) check_eq("start_once", bus.iniciar_out, 0);
      check_eq("wait_busy", bus.ocupado_out, 1);
      check_eq("wait_valid", bus.no_valid_out, 0);
      if (k == d + 1) begin
        bus.caminho_pronto_in  = 1'b1;
        bus.tamanho_caminho_in = LW'(tam);
        break;
      end
    end
    if (d + 1 > TO) begin
      @(negedge clk);
      check_eq("to_erro", bus.erro_out, 1);
      check_eq("to_idle", bus.ocupado_out, 0);
      check_eq("to_no_lido", bus.lido_out, 0);
      check_eq("to_reads", reads - rd0, 0);
      erro_exp = 1'b1;
      return;
    end
    if (len == 0) begin
      @(negedge clk);
      check_eq("empty_lido", bus.lido_out, 1);
      check_eq("empty_sem", bus.sem_caminho_out, 1);
      check_eq("empty_valid", bus.no_valid_out, 0);
      bus.caminho_pronto_in = 1'b0;
      @(negedge clk);
      check_eq("empty_lido_once", bus.lido_out, 0);
      check_eq("empty_sem_once", bus.sem_caminho_out, 0);
      check_eq("empty_idle", bus.ocupado_out, 0);
      check_eq("empty_reads", reads - rd0, 0);
      return;
    end
    for (int i = 0; i < len; i++) begin
      for (int g = 0; g < 2; g++) begin
        @(negedge clk);
        check_eq("gap_valid", bus.no_valid_out, 0);
        bus.no_ready_in = 1'($urandom_range(0, 1));
      end
      stall = (rmode == 2 && i == 1) ? 5 : ((rmode == 1) ? $urandom_range(0, 3) : 0);
      for (int s = 0; s <= stall; s++) begin
        @(negedge clk);
        check_eq("beat_valid", bus.no_valid_out, 1);
        check_eq("beat_data", bus.no_data_out, mem[i]);
        check_eq("beat_ultimo", bus.no_ultimo_out, (i == len - 1) ? 1 : 0);
        check_eq("beat_no_lido", bus.lido_out, 0);
        bus.no_ready_in = (s == stall);
      end
    end
    @(negedge clk);
    check_eq("done_lido", bus.lido_out, 1);
    check_eq("done_valid", bus.no_valid_out, 0);
    check_eq("done_busy", bus.ocupado_out, 1);
    check_eq("done_sem", bus.sem_caminho_out, 0);
    bus.caminho_pronto_in = 1'b0;
    bus.no_ready_in       = 1'b0;
    @(negedge clk);
    check_eq("done_lido_once", bus.lido_out, 0);
    check_eq("done_idle", bus.ocupado_out, 0);
    check_eq("done_reads", reads - rd0, len);
  endtask

  initial begin
    rst = 1'b1;
    bus.solicitar_in       = 1'b0;
    bus.aguardando_in      = 1'b0;
    bus.caminho_pronto_in  = 1'b0;
    bus.tamanho_caminho_in = '0;
    bus.no_ready_in        = 1'b0;
    fill_mem();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");

    mem[0] = 8'h05; mem[1] = 8'h12; mem[2] = 8'h2A;
    run_txn(2, 3, 0);
    run_txn(1, 3, 2);
    run_txn(0, 0, 0);
    run_txn(20, 3, 0);
    run_txn(9, 3, 1);
    fill_mem();
    run_txn(3, 70, 0);

    // Request while the controller is busy must be dropped.
    bus.solicitar_in  = 1'b1;
    bus.aguardando_in = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_eq("drop_iniciar", bus.iniciar_out, 0);
      check_eq("drop_busy", bus.ocupado_out, 0);
    end
    bus.solicitar_in  = 1'b0;
    bus.aguardando_in = 1'b1;
    @(negedge clk);
    check_eq("drop_not_queued", bus.ocupado_out, 0);

    for (int t = 0; t < 50; t++) begin
      int d, tam;
      fill_mem();
      d   = $urandom_range(0, 12);
      tam = ($urandom_range(0, 7) == 0) ? $urandom_range(60, 70) : $urandom_range(0, 9);
      run_txn(d, tam, $urandom_range(0, 1));
    end

    // Reset in the middle of streaming aborts everything.
    bus.solicitar_in  = 1'b1;
    bus.aguardando_in = 1'b1;
    @(negedge clk);
    bus.solicitar_in       = 1'b0;
    bus.caminho_pronto_in  = 1'b1;
    bus.tamanho_caminho_in = LW'(5);
    bus.no_ready_in        = 1'b0;
    for (int w = 0; w < 10 && !bus.no_valid_out; w++) @(negedge clk);
    check_eq("rst_reach_enviar", bus.no_valid_out, 1);
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    bus.caminho_pronto_in = 1'b0;
    @(negedge clk);
    check_all_zero("after_mid_reset");
    erro_exp = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
